// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder with scan mode.
package decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Bit 'line' of the one-hot code for index 'sel'.
   function automatic logic onehot(input int unsigned sel, input int unsigned line);
      return sel == line;
   endfunction

endpackage

// File: rtl/decoder_scan_dwell_counter.sv
// Dwell timer for scan mode: counts cycles on the current line, tick at DWELL-1.
module dwell_counter #(
   parameter int unsigned DWELL = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [CW-1:0] count_q, count_d;

   assign tick = (count_q == CW'(DWELL - 1));

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (run) begin
         count_d = tick ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot select driver with direct decode and timed scan.
//
// state     | meaning
// ST_IDLE   | disabled, all lines inactive, idx holds
// ST_DIRECT | line selected by a, one cycle latency
// ST_SCAN   | line steps through 0..2^N-1, DWELL cycles per line
module decoder_scan
   import decoder_pkg::*;
#(
   parameter int unsigned N          = 2,
   parameter int unsigned DWELL      = 4,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                mode,
   input  logic [N-1:0]        a,
   input  logic                load,
   output logic [(1<<N)-1:0]   d,
   output logic [N-1:0]        idx,
   output logic                wrap
);

   localparam int unsigned W = 1 << N;

   state_e         state_q, state_d;
   logic [N-1:0]   idx_q, idx_d;
   logic           wrap_q, wrap_d;
   logic [W-1:0]   d_q, d_d;
   logic           cnt_clr, cnt_run, tick;

   dwell_counter #(.DWELL(DWELL)) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .run   (cnt_run),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      cnt_clr = 1'b1;
      cnt_run = 1'b0;

      if (!en) begin
         state_d = ST_IDLE;
      end else if (mode == MODE_DIRECT) begin
         state_d = ST_DIRECT;
         idx_d   = a;
      end else begin
         state_d = ST_SCAN;
         if (state_q != ST_SCAN || load) begin
            idx_d = a;
         end else begin
            cnt_clr = 1'b0;
            cnt_run = 1'b1;
            if (tick) begin
               idx_d  = idx_q + 1'b1;
               wrap_d = &idx_q;
            end
         end
      end

      // Polarity is applied before the register so d is a pure flop output.
      d_d = {W{ACTIVE_LOW}};
      if (state_d != ST_IDLE) begin
         for (int unsigned i = 0; i < W; i++) begin
            d_d[i] = onehot(32'(idx_d), i) ^ ACTIVE_LOW;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         d_q     <= {W{ACTIVE_LOW}};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wrap_q  <= wrap_d;
         d_q     <= d_d;
      end
   end

   assign d    = d_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule
